// File: rtl/div_seq_pkg.sv
// Shared state encodings, width defaults and enable constants for the div_seq divider.
package div_seq_pkg;

    localparam int DIV_DW    = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// div_step: one combinational restoring shift-subtract iteration on the 2*DW+1 bit work register.
module div_step #(
    parameter int DW = 32
) (
    input  logic [2*DW:0]   work,
    input  logic [DW-1:0]   divisor,
    output logic [2*DW-1:0] work_shifted,
    output logic            q_bit
);
    logic [DW-1:0] diff;

    // The partial remainder never reaches 2*divisor, so a DW-bit difference is exact when it is kept.
    assign q_bit        = (work[2*DW:DW] >= {1'b0, divisor});
    assign diff         = work[2*DW-1:DW] - divisor;
    assign work_shifted = q_bit ? {diff, work[DW-1:0]} : work[2*DW-1:0];

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for MIPS DIV/DIVU with a one-cycle HI/LO write-back.
// Signed DIV support is built only when the DIV_SIGNED_EN macro is defined.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DW    = DIV_DW,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          signed_div,
    input  logic [DW-1:0] opdata1,
    input  logic [DW-1:0] opdata2,
    input  logic          annul,
    output logic          stall_req,
    output logic          ready,
    output logic          hilo_we,
    output logic [DW-1:0] result_hi,
    output logic [DW-1:0] result_lo
);
    div_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2*DW:0]    work_reg, work_next, work_step;
    logic [DW-1:0]    divisor_reg, divisor_next;
    logic [DW-1:0]    result_hi_reg, result_hi_next;
    logic [DW-1:0]    result_lo_reg, result_lo_next;
    logic             ready_reg, ready_next;
    logic             accept;
    logic [DW-1:0]    mag1, mag2, fix_hi, fix_lo;
    logic [2*DW-1:0]  step_upper;
    logic             step_q;

    assign accept = (state_reg == DIV_IDLE) && start && !annul;

    div_step #(.DW(DW)) u_step (
        .work         (work_reg),
        .divisor      (divisor_reg),
        .work_shifted (step_upper),
        .q_bit        (step_q)
    );

    assign work_step = {step_upper, step_q};

`ifdef DIV_SIGNED_EN
    logic neg_q_reg, neg_r_reg;
    logic op1_neg, op2_neg;

    assign op1_neg = signed_div && opdata1[DW-1];
    assign op2_neg = signed_div && opdata2[DW-1];
    assign mag1    = op1_neg ? -opdata1 : opdata1;
    assign mag2    = op2_neg ? -opdata2 : opdata2;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (accept) begin
            neg_q_reg <= op1_neg ^ op2_neg;
            neg_r_reg <= op1_neg;
        end
    end

    // Remainder follows the dividend's sign; quotient is negative when the signs differ.
    assign fix_lo = neg_q_reg ? -work_step[DW-1:0]     : work_step[DW-1:0];
    assign fix_hi = neg_r_reg ? -work_step[2*DW:DW+1] : work_step[2*DW:DW+1];
`else
    logic unused_signed_div;

    assign unused_signed_div = signed_div;
    assign mag1   = opdata1;
    assign mag2   = opdata2;
    assign fix_lo = work_step[DW-1:0];
    assign fix_hi = work_step[2*DW:DW+1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= DIV_IDLE;
            cnt_reg       <= '0;
            work_reg      <= '0;
            divisor_reg   <= '0;
            result_hi_reg <= '0;
            result_lo_reg <= '0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            work_reg      <= work_next;
            divisor_reg   <= divisor_next;
            result_hi_reg <= result_hi_next;
            result_lo_reg <= result_lo_next;
            ready_reg     <= ready_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        work_next      = work_reg;
        divisor_next   = divisor_reg;
        result_hi_next = result_hi_reg;
        result_lo_next = result_lo_reg;
        ready_next     = 1'b0;
        stall_req      = CHIP_DISABLE;

        case (state_reg)
            DIV_IDLE: begin
                if (accept) begin
                    stall_req    = CHIP_ENABLE;
                    divisor_next = mag2;
                    if (opdata2 == '0) begin
                        state_next = DIV_ZERO;
                    end else begin
                        work_next  = {{DW{1'b0}}, mag1, 1'b0};
                        cnt_next   = '0;
                        state_next = DIV_ON;
                    end
                end
            end
            DIV_ZERO: begin
                stall_req = CHIP_ENABLE;
                if (annul) begin
                    state_next = DIV_IDLE;
                end else begin
                    result_hi_next = '0;
                    result_lo_next = '0;
                    ready_next     = 1'b1;
                    state_next     = DIV_END;
                end
            end
            DIV_ON: begin
                stall_req = CHIP_ENABLE;
                if (annul) begin
                    state_next = DIV_IDLE;
                end else begin
                    work_next = work_step;
                    cnt_next  = cnt_reg + CNT_W'(1);
                    // Results are registered on the way into DIV_END so they appear alongside ready.
                    if (cnt_reg == CNT_W'(DW - 1)) begin
                        result_hi_next = fix_hi;
                        result_lo_next = fix_lo;
                        ready_next     = 1'b1;
                        state_next     = DIV_END;
                    end
                end
            end
            DIV_END: begin
                state_next = DIV_IDLE;
            end
            default: begin
                state_next = DIV_IDLE;
            end
        endcase
    end

    assign ready     = ready_reg;
    assign hilo_we   = ready_reg ? CHIP_ENABLE : CHIP_DISABLE;
    assign result_hi = result_hi_reg;
    assign result_lo = result_lo_reg;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed scenarios plus randomized divides against an arithmetic model.
module tb_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        annul = 1'b0;
    logic        stall_req, ready, hilo_we;
    logic [31:0] result_hi, result_lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always #5 clk = ~clk;

    div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .stall_req  (stall_req),
        .ready      (ready),
        .hilo_we    (hilo_we),
        .result_hi  (result_hi),
        .result_lo  (result_lo)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // MIPS DIV/DIVU reference: HI = remainder, LO = quotient, divide-by-zero gives zeros.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] hi, output logic [31:0] lo);
`ifdef DIV_SIGNED_EN
        int sa, sb;
        sa = a;
        sb = b;
`endif
        if (b == 32'd0) begin
            hi = '0;
            lo = '0;
        end
`ifdef DIV_SIGNED_EN
        else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            hi = '0;
            lo = 32'h8000_0000;
        end else if (sgn) begin
            lo = sa / sb;
            hi = sa % sb;
        end
`endif
        else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input bit junk, input bit annul_end, input string name);
        logic [31:0] exp_hi, exp_lo;
        logic        exp_rdy, exp_stall;
        int lat;
        model(a, b, sgn, exp_hi, exp_lo);
        lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b; annul = 1'b0;
        #1;
        checks++;
        if ({ready, hilo_we, stall_req} !== 3'b001) begin
            errors++;
            $display("FAIL %s accept: got rdy/we/stall=%b%b%b want 001", name, ready, hilo_we, stall_req);
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (junk && k < lat) begin
                start = 1'b1; opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            annul = annul_end && (k == lat);
            #1;
            exp_rdy   = (k == lat);
            exp_stall = (k < lat);
            checks++;
            if ({ready, hilo_we, stall_req} !== {exp_rdy, exp_rdy, exp_stall}) begin
                errors++;
                $display("FAIL %s handshake T+%0d: got rdy/we/stall=%b%b%b want %b%b%b", name, k,
                         ready, hilo_we, stall_req, exp_rdy, exp_rdy, exp_stall);
            end
            if (k == lat) begin
                checks++;
                if (result_hi !== exp_hi || result_lo !== exp_lo) begin
                    errors++;
                    $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name,
                             result_hi, result_lo, exp_hi, exp_lo);
                end
            end
        end
        annul = 1'b0;
        last_hi = exp_hi;
        last_lo = exp_lo;
        $display("%0t %s: %h / %h signed=%0b -> hi=%h lo=%h", $time, name, a, b, sgn, result_hi, result_lo);
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            start = 1'b0; annul = 1'b0;
            #1;
            checks++;
            if ({ready, hilo_we, stall_req} !== 3'b000 || result_hi !== last_hi || result_lo !== last_lo) begin
                errors++;
                $display("FAIL %s idle: got rdy/we/stall=%b%b%b hi=%h lo=%h want 000 hi=%h lo=%h", name,
                         ready, hilo_we, stall_req, result_hi, result_lo, last_hi, last_lo);
            end
        end
        $display("%0t %s: idle for %0d cycles", $time, name, cycles);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({ready, hilo_we, stall_req} !== 3'b000 || result_hi !== 32'd0 || result_lo !== 32'd0) begin
            errors++;
            $display("FAIL reset: got rdy/we/stall=%b%b%b hi=%h lo=%h want all zero",
                     ready, hilo_we, stall_req, result_hi, result_lo);
        end
        @(negedge clk);
        rst = 1'b0;
        last_hi = '0;
        last_lo = '0;
        check_idle("reset_release", 2);
    endtask

    task automatic test_basic();
        run_div(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, "divu_100_7");
        run_div(32'd5, 32'd0, 1'b0, 1'b0, 1'b0, "divu_5_0");
        check_idle("after_basic", 1);
    endtask

    task automatic test_signed();
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0, "div_m7_2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "div_min_m1");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, "divu_m7_2");
    endtask

    task automatic test_annul();
        // Cancel mid-iteration.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            annul = (k == 10);
            #1;
            checks++;
            if ({ready, stall_req} !== 2'b01) begin
                errors++;
                $display("FAIL annul_on busy T+%0d: got rdy/stall=%b%b want 01", k, ready, stall_req);
            end
        end
        check_idle("annul_on", 3);
        run_div(32'd9, 32'd3, 1'b0, 1'b0, 1'b0, "after_annul_9_3");
        // Cancel during the divide-by-zero cycle.
        @(negedge clk);
        start = 1'b1; opdata1 = 32'd5; opdata2 = 32'd0;
        @(negedge clk);
        start = 1'b0; annul = 1'b1;
        check_idle("annul_zero", 3);
        // annul alongside start in IDLE: request refused.
        @(negedge clk);
        start = 1'b1; annul = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL annul_start stall: got %b want 0", stall_req);
        end
        check_idle("annul_start", 35);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd7;
        repeat (15) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_hi = '0;
        last_lo = '0;
        check_idle("reset_mid", 2);
        run_div(32'd77, 32'd7, 1'b0, 1'b1, 1'b0, "held_start_77_7");
    endtask

    task automatic test_back_to_back();
        run_div(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, 1'b1, "b2b_first");
        run_div(32'd20, 32'd4, 1'b0, 1'b0, 1'b0, "b2b_second");
        check_idle("after_b2b", 1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        int sel;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = a;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_div(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), "random");
        end
        check_idle("after_random", 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for MIPS DIV/DIVU in the EX stage.
- Accepts one divide request, runs a 32-iteration restoring shift-subtract loop and stalls the pipeline while busy.
- On completion, presents remainder/quotient with a one-cycle write enable for the HI/LO register file (HI = remainder, LO = quotient).
- Supports cancellation when the issuing instruction is flushed.

Parameters:
- DW, 32, operand/result width; the iteration count equals DW.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DW.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  divide request from EX; sampled only in IDLE
- signed_div  in  1  1 = DIV (signed), 0 = DIVU
- opdata1  in  DW  dividend (rs)
- opdata2  in  DW  divisor (rt)
- annul  in  1  flush/cancel of the in-flight divide
- stall_req  out  1  pipeline stall request to the control unit
- ready  out  1  result valid; high for exactly one cycle
- hilo_we  out  1  HI/LO write enable; equals ready
- result_hi  out  DW  remainder
- result_lo  out  DW  quotient

Behaviour:
- All state is clocked on posedge clk. rst is synchronous and active-high; it has priority over everything, including mid-operation.
- Reset values: state = IDLE, cnt = 0, work register = 0, result_hi = 0, result_lo = 0, ready = 0, hilo_we = 0, stall_req = 0.
- States: IDLE, DIV_ZERO, DIV_ON, DIV_END.
- IDLE:
  - If start=1 and annul=0: latch operands.
  - If opdata2 == 0, go to DIV_ZERO. Otherwise load work = {DW'b0, |opdata1|, 1'b0} (the 2DW+1-bit dividend/partial-remainder register), set cnt = 0 and go to DIV_ON.
  - Absolute values apply only when signed_div=1 and the feature is enabled.
- DIV_ZERO: one cycle. Result is forced to hi = 0, lo = 0. Next state is DIV_END.
- DIV_ON, one iteration per cycle:
  - diff = work[2DW:DW] - divisor.
  - If diff is negative, work = work << 1. Otherwise work = {diff[DW-1:0], work[DW-1:0], 1'b1} shifted so the quotient bit enters LSB.
  - cnt increments each iteration.
  - When cnt == DW-1 completes, go to DIV_END.
- DIV_END: one cycle.
  - result_lo = quotient and result_hi = remainder, with sign correction applied.
  - ready = 1 and hilo_we = 1 for this cycle only.
  - Next state is IDLE.
- Latency: accept cycle T, ready at T+DW+1 (T+33 for DW=32). Divide-by-zero: ready at T+2.
- stall_req = (IDLE & start & ~annul) | DIV_ZERO | DIV_ON. It is deasserted in DIV_END so the pipeline advances in the same cycle HI/LO are written.
- result_hi/result_lo hold their last value after DIV_END until the next completion.
- annul=1 in DIV_ZERO/DIV_ON: go to IDLE next cycle, with no ready, no hilo_we and outputs unchanged.
- annul=1 in DIV_END: has no effect; the write proceeds.
- annul together with start in IDLE: the request is not accepted and stall_req = 0.
- start while not in IDLE: ignored. The operands of the in-flight op are held internally, so the inputs may change freely.
- Back-to-back: start asserted in the cycle after DIV_END is accepted normally.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined:
  - When signed_div=1, operands are converted to magnitude at accept.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields lo = 0x80000000, hi = 0.
- Undefined: signed_div is ignored and all divides are unsigned. Negation logic is not synthesized.

Decomposition:
- Shared defines header holds:
  - state encodings (DIV_IDLE, DIV_ZERO, DIV_ON, DIV_END, 2 bits)
  - DW/iteration count
  - the ChipEnable/ChipDisable constants used by hilo_we/stall_req
- One sub-module: div_step, a combinational single restoring iteration (partial remainder in, divisor in, shifted remainder out, quotient bit out). It is instantiated once; div_seq owns the FSM, counter and sign fixup.

Test Plan:
- DIVU 100 / 7 -> stall_req high T..T+32, ready/hilo_we at T+33 only, hi = 2, lo = 14.
- DIVU 5 / 0 -> ready at T+2, hi = 0, lo = 0, stall_req high T and T+1 only.
- DIV (DIV_SIGNED_EN) -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- Start DIVU 1000 / 3, assert annul at iteration 10 -> IDLE next cycle, no ready/hilo_we, stall_req low. A new 9 / 3 issued the following cycle -> lo = 3, hi = 0 at +33.
- rst pulsed mid-DIV_ON -> next cycle all outputs 0, state IDLE. Start held during busy with changed operands -> result reflects the original operands only.
- Back-to-back: 0xFFFFFFFF / 0x10 then start the cycle after ready for 20 / 4 -> lo = 0x0FFFFFFF, hi = 0xF, then lo = 5, hi = 0, each ready exactly one cycle.
